// File: rtl/access_pkg.sv
// Shared definitions for the parking gate access path: keypad codes, PIN
// geometry shared with the access FSM, and the PIN collector state encoding.
package access_pkg;

  localparam int PIN_DIGITS = 4;
  localparam int PIN_W      = PIN_DIGITS * 4;

  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;
  localparam logic [3:0] KEY_BACKSPACE = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2
  } collect_state_t;

  // 0x0-0x9 are digits; everything above is a command or an ignored code.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_inactivity_timer.sv
// Idle-cycle counter for the PIN collector.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   enable       : counting allowed (collector is in COLLECT); low holds 0
//   clear        : restart from 0 this cycle (key accepted or abort)
//   expire       : combinational, high in the cycle the count sits at
//                  TIMEOUT_CYCLES-1 with no clear; the counter restarts too
module pin_inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // A clear in the expiry cycle wins, so a late key keeps the entry alive.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clock) begin
    if (!reset || !enable || clear || expire) count <= '0;
    else                                      count <= count + 1'b1;
  end

endmodule

// File: rtl/pin_keypad_collector.sv
// Keypad PIN collector: assembles BCD digits into a packed PIN (first digit
// in the top nibble) and offers it to the access controller with valid/ack.
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   key_valid/ready   : keycode handshake from the keypad scanner
//   key_code          : 0-9 digit, A clear, B enter, C backspace, D-F ignored
//   abort             : controller discards entry, back to IDLE
//   pin, pin_valid    : offered PIN, held stable while pin_valid
//   pin_ack           : controller consumed the PIN
//   digit_count       : digits currently held
//   entry_error       : one-cycle pulse, bad ENTER or digit overflow
//   entry_timeout     : one-cycle pulse, partial entry dropped for inactivity
module pin_keypad_collector
  import access_pkg::*;
#(
  parameter int DIGITS         = PIN_DIGITS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  key_ready,
  input  logic                  abort,
  output logic [DIGITS*4-1:0]   pin,
  output logic                  pin_valid,
  input  logic                  pin_ack,
  output logic [2:0]            digit_count,
  output logic                  entry_error,
  output logic                  entry_timeout
);

  localparam int         W    = DIGITS * 4;
  localparam logic [2:0] FULL = 3'(DIGITS);

  collect_state_t state_q, state_d;
  logic [W-1:0]   pin_q, pin_d;
  logic [2:0]     count_q, count_d;
  logic           err_d, tmo_d;
  logic           key_accept;
  logic           expire;

  assign key_ready  = (state_q != ST_PRESENT);
  assign key_accept = key_valid && key_ready;

  pin_inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .enable(state_q == ST_COLLECT),
    .clear (key_accept || abort),
    .expire(expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pin_q         <= '0;
      count_q       <= '0;
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      pin_q         <= pin_d;
      count_q       <= count_d;
      entry_error   <= err_d;
      entry_timeout <= tmo_d;
    end
  end

  // Priority: abort > key > timeout. pin is always 0 in IDLE, so the first
  // digit can be loaded directly.
  always_comb begin
    state_d = state_q;
    pin_d   = pin_q;
    count_d = count_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      pin_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_accept) begin
            if (is_digit(key_code)) begin
              pin_d   = W'(key_code);
              count_d = 3'd1;
              state_d = ST_COLLECT;
            end else if (key_code == KEY_ENTER) begin
              err_d = 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (key_accept) begin
            if (is_digit(key_code)) begin
              if (count_q < FULL) begin
                pin_d   = (pin_q << 4) | W'(key_code);
                count_d = count_q + 3'd1;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              case (key_code)
                KEY_CLEAR: begin
                  pin_d   = '0;
                  count_d = '0;
                  state_d = ST_IDLE;
                end
                KEY_BACKSPACE: begin
                  pin_d   = pin_q >> 4;
                  count_d = count_q - 3'd1;
                  if (count_q == 3'd1) state_d = ST_IDLE;
                end
                KEY_ENTER: begin
                  if (count_q == FULL) begin
                    state_d = ST_PRESENT;
                  end else begin
                    err_d   = 1'b1;
                    pin_d   = '0;
                    count_d = '0;
                    state_d = ST_IDLE;
                  end
                end
                default: ;  // D-F: consumed, only restarts the timer
              endcase
            end
          end else if (expire) begin
            tmo_d   = 1'b1;
            pin_d   = '0;
            count_d = '0;
            state_d = ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (pin_ack) begin
            pin_d   = '0;
            count_d = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          pin_d   = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign pin         = pin_q;
  assign pin_valid   = (state_q == ST_PRESENT);
  assign digit_count = count_q;

endmodule

// File: tb/tb_pin_keypad_collector.sv
// Directed bench for pin_keypad_collector with a queue-based reference model
// checked on every cycle, plus literal expectations at key points.
module tb_pin_keypad_collector;

  localparam int TMO = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        abort;
  logic [15:0] pin;
  logic        pin_valid;
  logic        pin_ack;
  logic [2:0]  digit_count;
  logic        entry_error;
  logic        entry_timeout;

  int checks   = 0;
  int failures = 0;

  pin_keypad_collector #(.DIGITS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .abort        (abort),
    .pin          (pin),
    .pin_valid    (pin_valid),
    .pin_ack      (pin_ack),
    .digit_count  (digit_count),
    .entry_error  (entry_error),
    .entry_timeout(entry_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the entry is simply the list of digits typed so far.
  int unsigned m_digs[$];
  bit          m_present, m_err, m_tmo, m_live;
  int          m_idle;

  function automatic logic [15:0] m_pin();
    logic [15:0] p = '0;
    foreach (m_digs[i]) p = (p << 4) | 16'(m_digs[i]);
    return p;
  endfunction

  always @(posedge clock) begin
    m_err = 0;
    m_tmo = 0;
    if (!reset) begin
      m_digs.delete(); m_present = 0; m_idle = 0; m_live = 1;
    end else if (abort) begin
      m_digs.delete(); m_present = 0; m_idle = 0;
    end else if (m_present) begin
      if (pin_ack) begin m_present = 0; m_digs.delete(); end
    end else if (key_valid) begin
      m_idle = 0;
      if (key_code <= 4'd9) begin
        if (m_digs.size() < 4) m_digs.push_back(int'(key_code));
        else m_err = 1;
      end else if (key_code == 4'hA) begin
        m_digs.delete();
      end else if (key_code == 4'hC) begin
        if (m_digs.size() > 0) void'(m_digs.pop_back());
      end else if (key_code == 4'hB) begin
        if (m_digs.size() == 4) m_present = 1;
        else begin m_err = 1; m_digs.delete(); end
      end
    end else if (m_digs.size() > 0) begin
      if (m_idle == TMO - 1) begin m_tmo = 1; m_digs.delete(); m_idle = 0; end
      else m_idle++;
    end else begin
      m_idle = 0;
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      chk("pin",           32'(pin),           32'(m_pin()));
      chk("pin_valid",     32'(pin_valid),     32'(m_present));
      chk("key_ready",     32'(key_ready),     32'(!m_present));
      chk("digit_count",   32'(digit_count),   32'(m_digs.size()));
      chk("entry_error",   32'(entry_error),   32'(m_err));
      chk("entry_timeout", 32'(entry_timeout), 32'(m_tmo));
    end
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ack();
    pin_ack = 1'b1;
    @(negedge clock);
    pin_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_code = 4'h0; abort = 1'b0; pin_ack = 1'b0;
    idle(2);
    chk("rst_pin", 32'(pin), 32'h0);
    chk("rst_ready", 32'(key_ready), 32'h1);
    chk("rst_valid", 32'(pin_valid), 32'h0);
    reset = 1'b1;
    idle(1);

    // 1: 2,4,6,8 ENTER, ack after 3 cycles
    press(4'h2); press(4'h4); press(4'h6); press(4'h8); press(4'hB);
    chk("t1_pin", 32'(pin), 32'h2468);
    chk("t1_valid", 32'(pin_valid), 32'h1);
    idle(2);
    ack();
    chk("t1_valid_low", 32'(pin_valid), 32'h0);
    chk("t1_count", 32'(digit_count), 32'h0);
    chk("t1_ready", 32'(key_ready), 32'h1);

    // 2: backspace editing
    press(4'h1); press(4'h2); press(4'h3); press(4'hC); press(4'h5); press(4'h9); press(4'hB);
    chk("t2_pin", 32'(pin), 32'h1259);
    ack();

    // 3: short ENTER, then overflow digit
    press(4'h1); press(4'h2); press(4'hB);
    chk("t3_err", 32'(entry_error), 32'h1);
    chk("t3_count", 32'(digit_count), 32'h0);
    idle(1);
    chk("t3_err_pulse", 32'(entry_error), 32'h0);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk("t3_ovf_err", 32'(entry_error), 32'h1);
    chk("t3_ovf_pin", 32'(pin), 32'h1234);
    press(4'hE);  // ignored code
    press(4'hA);
    chk("t3_clear", 32'(digit_count), 32'h0);

    // 4: inactivity timeout, then a key in the expiry cycle
    press(4'h7); press(4'h3);
    idle(TMO - 1);
    chk("t4_no_tmo_yet", 32'(entry_timeout), 32'h0);
    idle(1);
    chk("t4_tmo", 32'(entry_timeout), 32'h1);
    chk("t4_count", 32'(digit_count), 32'h0);
    idle(1);
    chk("t4_tmo_pulse", 32'(entry_timeout), 32'h0);
    press(4'h7); press(4'h3);
    idle(TMO - 1);
    press(4'h1);
    chk("t4_saved_tmo", 32'(entry_timeout), 32'h0);
    chk("t4_saved_cnt", 32'(digit_count), 32'h3);
    press(4'hA);

    // 5: keys blocked while presenting; abort with ack
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hB);
    key_valid = 1'b1; key_code = 4'h5;
    idle(2);
    chk("t5_ready", 32'(key_ready), 32'h0);
    chk("t5_pin", 32'(pin), 32'h9876);
    abort = 1'b1; pin_ack = 1'b1; key_valid = 1'b0;
    @(negedge clock);
    abort = 1'b0; pin_ack = 1'b0;
    chk("t5_valid", 32'(pin_valid), 32'h0);
    chk("t5_err", 32'(entry_error), 32'h0);
    chk("t5_tmo", 32'(entry_timeout), 32'h0);
    // abort mid-entry as well
    press(4'h3);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    chk("t5_abort_cnt", 32'(digit_count), 32'h0);

    // 6: reset mid-entry and mid-handshake
    press(4'h1); press(4'h2);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    chk("t6_cnt", 32'(digit_count), 32'h0);
    chk("t6_pin", 32'(pin), 32'h0);
    press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(4'hB);
    chk("t6_present", 32'(pin_valid), 32'h1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    chk("t6_valid", 32'(pin_valid), 32'h0);
    chk("t6_ready", 32'(key_ready), 32'h1);
    chk("t6_pin2", 32'(pin), 32'h0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
